uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (parallel-in, serial-out; parity enable/type per frame; handshake `data_valid` in, `busy` out) between NUM_REQ byte requesters.
- Round-robin arbitration; latches the winner's byte and parity settings; pulses the transmitter's data_valid once.
- Holds data and parity inputs stable for the whole frame, because the transmitter computes parity combinationally from its data input.
- Sits between the requester logic and the UART top, driving `i_p_data`, `i_parity_enable`, `i_parity_type` and `i_data_valid`.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 81 ++++++++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit arbiter slice.
//   - arb_state_e : arbiter FSM states
//   - UART_DATA_W : data width of the shared UART transmitter
//   - idx_w()     : clog2 with a floor of 1, for index and counter widths
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Bits needed to index n items. Never returns less than 1, so a
  // two-entry vector still gets a one-bit index.
  function automatic int idx_w(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Picks one requester from a request vector.
//   Default build: round robin. The scan starts at a registered pointer and
//   wraps modulo NUM_REQ. On an advance strobe with a live request, the
//   pointer moves to winner+1.
//   With UART_ARB_FIXED_PRIO_EN defined, the lowest set index always wins
//   and the pointer does not exist.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (pointer back to 0)
//   req      in   [NUM_REQ]  request vector
//   advance  in   the current pick is being consumed this cycle
//   grant    out  [NUM_REQ]  one-hot winner (all zero when req == 0)
//   idx      out  [IW]       index of the winner (0 when req == 0)
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

`ifdef UART_ARB_FIXED_PRIO_EN

  // Walk from the top index down. The last hit is the lowest set bit.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) idx = IW'(i);
    end
    if (|req) grant[idx] = 1'b1;
  end

`else

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;
  int            j;

  // Masked-priority scan: the candidate order is ptr, ptr+1, ...
  // wrapped by a subtraction so NUM_REQ need not be a power of two.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && (|req)) begin
      ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte requesters.
//   In IDLE, with the transmitter not busy and at least one request, the
//   block picks a winner, latches its byte and parity settings, and pulses
//   o_tx_valid and o_grant for one cycle (ISSUE). It then waits up to
//   BUSY_WAIT cycles for the transmitter to raise busy (WAIT_BUSY). After
//   that it waits for busy to fall (WAIT_DONE).
//   The data and parity outputs are held from one capture to the next. The
//   transmitter derives parity combinationally from them, so they must not
//   move mid-frame.
//
//   Configuration macro: UART_ARB_FIXED_PRIO_EN
//     undefined : round-robin arbitration (default)
//     defined   : fixed priority, lowest index wins
//
// Ports
//   i_clk           in   clock
//   i_rst           in   synchronous active-low reset
//   i_req           in   [NUM_REQ]        request levels
//   i_req_data      in   [NUM_REQ*DATA_W] byte k at [k*DATA_W +: DATA_W]
//   i_req_par_en    in   [NUM_REQ]        per-requester parity enable
//   i_req_par_type  in   [NUM_REQ]        per-requester parity type
//   o_grant         out  [NUM_REQ]        one-cycle one-hot capture pulse
//   i_tx_busy       in   transmitter busy
//   o_tx_data       out  [DATA_W]         transmitter parallel data
//   o_tx_par_en     out  transmitter parity enable
//   o_tx_par_type   out  transmitter parity type
//   o_tx_valid      out  transmitter data_valid (one-cycle pulse)
//   o_owner         out  [clog2 NUM_REQ]  current or last granted index
//   o_active        out  frame in flight (state != IDLE)
//   o_err           out  one-cycle pulse: busy never seen after valid
//
// Handshake: a requester holds i_req and its data/parity steady until it
// sees its o_grant bit. The byte is captured on the edge that raises
// o_grant. The requester may change everything from the next cycle on.
// Toward the transmitter, o_tx_valid is a single-cycle strobe. Busy must
// rise within BUSY_WAIT cycles; otherwise the frame is abandoned with o_err.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = UART_DATA_W,
  parameter  int BUSY_WAIT = 4,
  localparam int OW        = idx_w(NUM_REQ),
  localparam int CW        = idx_w(BUSY_WAIT + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_par_en,
  input  logic [NUM_REQ-1:0]        i_req_par_type,
  output logic [NUM_REQ-1:0]        o_grant,
  input  logic                      i_tx_busy,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_par_en,
  output logic                      o_tx_par_type,
  output logic                      o_tx_valid,
  output logic [OW-1:0]             o_owner,
  output logic                      o_active,
  output logic                      o_err
);

  arb_state_e          state;
  logic [CW-1:0]       wait_cnt;
  logic                capture;
  logic [NUM_REQ-1:0]  win_grant;
  logic [OW-1:0]       win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                win_par_en;
  logic                win_par_type;

  assign capture = (state == IDLE) && !i_tx_busy && (|i_req);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .req     (i_req),
    .advance (capture),
    .grant   (win_grant),
    .idx     (win_idx)
  );

  // The one-hot grant selects the winner's byte. This avoids a
  // variable-offset part select.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_grant[k]) win_data = i_req_data[k*DATA_W +: DATA_W];
    end
  end

  assign win_par_en   = |(win_grant & i_req_par_en);
  assign win_par_type = |(win_grant & i_req_par_type);

  assign o_active = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_grant       <= '0;
      o_tx_data     <= '0;
      o_tx_par_en   <= 1'b0;
      o_tx_par_type <= 1'b0;
      o_tx_valid    <= 1'b0;
      o_owner       <= '0;
      o_err         <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state below sets them.
      o_grant    <= '0;
      o_tx_valid <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state         <= ISSUE;
            o_tx_valid    <= 1'b1;
            o_grant       <= win_grant;
            o_owner       <= win_idx;
            o_tx_data     <= win_data;
            o_tx_par_en   <= win_par_en;
            o_tx_par_type <= win_par_type;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // The count reaches BUSY_WAIT on this edge. The grant is
            // already consumed, so the frame is dropped, not retried.
            if (wait_cnt == CW'(BUSY_WAIT - 1)) begin
              o_err <= 1'b1;
              state <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, BUSY_WAIT=4).
//   The transmitter's busy line is driven by hand from the stimulus.
//   Build with UART_ARB_FIXED_PRIO_EN to run the fixed-priority sequence
//   in place of the round-robin fairness sequence.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             i_clk;
  logic             i_rst;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_req_data;
  logic [N-1:0]     i_req_par_en;
  logic [N-1:0]     i_req_par_type;
  logic [N-1:0]     o_grant;
  logic             i_tx_busy;
  logic [W-1:0]     o_tx_data;
  logic             o_tx_par_en;
  logic             o_tx_par_type;
  logic             o_tx_valid;
  logic [1:0]       o_owner;
  logic             o_active;
  logic             o_err;

  int n_vec = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .BUSY_WAIT (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_req_data     (i_req_data),
    .i_req_par_en   (i_req_par_en),
    .i_req_par_type (i_req_par_type),
    .o_grant        (o_grant),
    .i_tx_busy      (i_tx_busy),
    .o_tx_data      (o_tx_data),
    .o_tx_par_en    (o_tx_par_en),
    .o_tx_par_type  (o_tx_par_type),
    .o_tx_valid     (o_tx_valid),
    .o_owner        (o_owner),
    .o_active       (o_active),
    .o_err          (o_err)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one edge, then settle 1 time unit past it. All checks and
  // input changes happen here.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst     = 1'b0;
    i_req     = '0;
    i_tx_busy = 1'b0;
    step();
    step();
    i_rst = 1'b1;
  endtask

  task automatic set_req_byte(input int k, input logic [W-1:0] d,
                              input logic pe, input logic pt);
    i_req_data[k*W +: W] = d;
    i_req_par_en[k]      = pe;
    i_req_par_type[k]    = pt;
  endtask

  // Called in the ISSUE cycle. Runs the transmitter through one frame and
  // returns in the IDLE cycle that follows busy falling.
  task automatic finish_frame(input int busy_len);
    step();
    i_tx_busy = 1'b1;
    repeat (busy_len) step();
    i_tx_busy = 1'b0;
    step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] g;
    logic [N-1:0] pe_tab;
    logic [N-1:0] pt_tab;
    int           k;

    i_req_data     = '0;
    i_req_par_en   = '0;
    i_req_par_type = '0;
    apply_reset();

    // Reset state
    check("rst_grant",  o_grant,       0);
    check("rst_valid",  o_tx_valid,    0);
    check("rst_data",   o_tx_data,     0);
    check("rst_par_en", o_tx_par_en,   0);
    check("rst_owner",  o_owner,       0);
    check("rst_active", o_active,      0);
    check("rst_err",    o_err,         0);

    // Single request: requester 2, byte A5, even parity enabled
    set_req_byte(0, 8'h11, 1'b0, 1'b1);
    set_req_byte(1, 8'h22, 1'b0, 1'b1);
    set_req_byte(2, 8'hA5, 1'b1, 1'b0);
    set_req_byte(3, 8'h44, 1'b0, 1'b1);
    i_req = 4'b0100;
    step();
    check("single_grant",    o_grant,       4'b0100);
    check("single_valid",    o_tx_valid,    1);
    check("single_owner",    o_owner,       2);
    check("single_data",     o_tx_data,     8'hA5);
    check("single_par_en",   o_tx_par_en,   1);
    check("single_par_type", o_tx_par_type, 0);
    check("single_active",   o_active,      1);
    i_req = '0;
    set_req_byte(2, 8'h00, 1'b0, 1'b1);
    step();
    check("single_valid_drop", o_tx_valid, 0);
    check("single_grant_drop", o_grant,    0);
    i_tx_busy = 1'b1;
    for (int c = 0; c < 11; c++) begin
      step();
      check("single_hold_data",   o_tx_data,     8'hA5);
      check("single_hold_active", o_active,      1);
      check("single_hold_par",    o_tx_par_en,   1);
    end
    i_tx_busy = 1'b0;
    step();
    check("single_end_active", o_active,  0);
    check("single_end_data",   o_tx_data, 8'hA5);
    check("single_end_valid",  o_tx_valid, 0);

    // Busy at request: no grant while the transmitter is busy
    set_req_byte(0, 8'h3C, 1'b1, 1'b1);
    i_tx_busy = 1'b1;
    i_req     = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      check("busyreq_no_grant", o_grant,    0);
      check("busyreq_no_valid", o_tx_valid, 0);
      check("busyreq_idle",     o_active,   0);
    end
    i_tx_busy = 1'b0;
    step();
    check("busyreq_grant",    o_grant,       4'b0001);
    check("busyreq_valid",    o_tx_valid,    1);
    check("busyreq_data",     o_tx_data,     8'h3C);
    check("busyreq_par_type", o_tx_par_type, 1);
    i_req = '0;
    finish_frame(3);
    check("busyreq_end", o_active, 0);

    // Continuous requests: round-robin order, or a fixed winner
    apply_reset();
    pe_tab = 4'b0101;
    pt_tab = 4'b0011;
    for (int i = 0; i < N; i++) set_req_byte(i, 8'h10 + 8'(i), pe_tab[i], pt_tab[i]);
`ifdef UART_ARB_FIXED_PRIO_EN
    i_req = 4'b1010;
    for (int f = 0; f < 5; f++) exp_q.push_back(4'b0010);
`else
    i_req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
`endif
    for (int f = 0; f < 5; f++) begin
      g = exp_q.pop_front();
      k = onehot_idx(g);
      step();
      check("seq_valid",  o_tx_valid,  1);
      check("seq_grant",  o_grant,     g);
      check("seq_owner",  o_owner,     k);
      check("seq_data",   o_tx_data,   8'h10 + 8'(k));
      check("seq_par_en", o_tx_par_en, pe_tab[k]);
      step();
      i_tx_busy = 1'b1;
      step();
      step();
      step();
      i_tx_busy = 1'b0;
      step();
      check("seq_gap", o_tx_valid, 0);
    end
    i_req = '0;
    step();

    // Busy timeout: busy never rises, err 5 cycles after valid
    i_req = 4'b0010;
    step();
    check("tmo_grant", o_grant,    4'b0010);
    check("tmo_valid", o_tx_valid, 1);
    i_req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("tmo_no_err", o_err, 0);
    end
    step();
    check("tmo_err",    o_err,    1);
    check("tmo_idle",   o_active, 0);
    step();
    check("tmo_err_clr",    o_err,      0);
    check("tmo_next_grant", o_grant,    4'b0100);
    check("tmo_next_valid", o_tx_valid, 1);
    i_req = '0;
    finish_frame(2);

    // Reset mid-frame: reset in WAIT_DONE, then arbitration restarts at 0
    set_req_byte(1, 8'h5A, 1'b1, 1'b1);
    i_req = 4'b0110;
    step();
    check("midrst_grant", o_grant,   4'b0010);
    check("midrst_data",  o_tx_data, 8'h5A);
    i_req = 4'b0100;
    step();
    i_tx_busy = 1'b1;
    step();
    step();
    check("midrst_busy_active", o_active, 1);
    i_rst     = 1'b0;
    i_tx_busy = 1'b0;
    i_req     = 4'b0101;
    step();
    check("midrst_grant0",   o_grant,       0);
    check("midrst_valid0",   o_tx_valid,    0);
    check("midrst_data0",    o_tx_data,     0);
    check("midrst_par_en0",  o_tx_par_en,   0);
    check("midrst_par_typ0", o_tx_par_type, 0);
    check("midrst_owner0",   o_owner,       0);
    check("midrst_active0",  o_active,      0);
    check("midrst_err0",     o_err,         0);
    i_rst = 1'b1;
    step();
    check("midrst_regrant", o_grant, 4'b0001);
    check("midrst_owner",   o_owner, 0);
    i_req = '0;
    finish_frame(2);
    check("midrst_end", o_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
